transmissor_perfil_serial: RTL and testbench
============================================

# transmissor_perfil_serial

Serial transmitter for a user-profile code. Accepts a 3-bit profile over a valid/ready handshake and sends it on a single wire as a framed serial word: start bit, 3 data bits LSB first, even parity, stop bit. It sits at the source end of the profile-transfer interface, upstream of the profile receive/pass-through logic. Profile code 000 means "no profile" and is never transmitted.

## Interface
- DIV_BAUD, 4: clock cycles per serial bit; legal values are 1 and above.
- LARGURA_PERFIL, 3: profile width. Fixed at 3. Other values are unsupported.
- clk  in  1  system clock; the only clock domain.
- reset  in  1  reset; synchronous, active-high.
- perfil  in  3  profile code to send; sampled only on acceptance.
- valido  in  1  perfil is valid this cycle.
- pronto  out  1  ready; high only in IDLE.
- tx  out  1  serial line; idles high; registered.
- ocupado  out  1  high while a frame is in flight (START through STOP).
- fim  out  1  one-cycle pulse on return to IDLE after a complete frame.

## Operation
- Acceptance: valido=1, pronto=1 and perfil≠000 at a rising edge. The profile is latched into an internal shift register, and the even parity bit (XOR of the 3 bits) is latched with it.
- valido=1 with perfil=000 is ignored: no state change, pronto stays 1, no frame is sent.
- FSM states and transitions:
  - IDLE → START on acceptance.
  - START → DADOS after DIV_BAUD cycles.
  - DADOS → PARIDADE after 3·DIV_BAUD cycles. The bit counter counts 0..2, and data bit i is sent as perfil[i].
  - PARIDADE → STOP after DIV_BAUD cycles.
  - STOP → IDLE after DIV_BAUD cycles, asserting fim.
- tx value per state: IDLE=1, START=0, DADOS=current bit, PARIDADE=parity, STOP=1.
- perfil and valido changes during a frame have no effect.
- pronto = (state==IDLE). ocupado = !pronto.
- Reset values: state IDLE, tx=1, pronto=1, ocupado=0, fim=0, counters 0.
- Reset mid-frame aborts the frame. The cycle after the reset edge shows tx=1 and pronto=1, and no fim is issued for the aborted frame.
- Reset has priority over acceptance in the same cycle.

## Timing
- Let acceptance occur at edge k and let D = DIV_BAUD.
- Start bit: tx=0 over [k, k+D).
- Data bit i: over [k+(1+i)D, k+(2+i)D).
- Parity bit: over [k+4D, k+5D).
- Stop bit: over [k+5D, k+6D).
- At edge k+6D the FSM is in IDLE: pronto=1 and fim=1 for exactly one cycle.
- Back-to-back transfers: acceptance is allowed in the fim cycle, so the next start bit begins at edge k+6D+1. The minimum frame period is 6D+1 cycles, with 1 extra idle-high cycle.
- Latency from acceptance to the first tx transition is 0 cycles; tx is already 0 in the cycle following the accepting edge.
- D=1 is legal: each bit lasts one cycle and the period is 7 cycles.
- Bit-period counter width is clog2(DIV_BAUD)+1. The counter wraps to 0 on each bit boundary.

## Structure
- Shared package `perfil_pkg` holds:
  - the state encoding constants (IDLE, START, DADOS, PARIDADE, STOP);
  - LARGURA_PERFIL;
  - PERFIL_NULO = 3'b000;
  - BITS_QUADRO = 6.
- The natural sub-module is `divisor_baud`, a bit-period tick generator. It is cleared on acceptance and on reset, and emits a 1-cycle tick every DIV_BAUD cycles. The FSM advances only on that tick.
- The parity and shift register stay in the top level.

## Test plan
- After reset, with D=4 and no stimulus: tx=1, pronto=1, ocupado=0 and fim=0 hold for 20 cycles.
- D=4, perfil=101 with valido=1 for one cycle: tx sequence over 24 cycles is 0×4, 1×4, 0×4, 1×4, 0×4 (parity), 1×4. Then fim pulses once in the cycle at edge k+24, and pronto=1.
- D=4, perfil=111 with valido held high across two frames: parity bit is 1 in both frames. The second start bit begins exactly 25 cycles after the first. fim pulses twice.
- perfil=000 with valido=1 for 10 cycles: pronto stays 1, tx stays 1, ocupado stays 0, and no fim occurs.
- D=4, perfil=100, with reset asserted at cycle 9 of the frame and perfil changed to 011 during the frame: tx=1 and pronto=1 on the next cycle, and no fim. A new frame with 011 afterwards sends bits 1,1,0 with parity 0.
- D=1, perfil=100: tx is 0,0,0,1,1,1 on consecutive cycles, then fim. The next acceptance is possible 7 cycles after the first.

Source files
------------

// File: rtl/transmissor_perfil_serial_pkg.sv
// rtl/transmissor_perfil_serial_pkg.sv - shared constants and state encoding for the profile transmitter
package perfil_pkg;

  localparam int LARGURA_PERFIL = 3;
  localparam logic [LARGURA_PERFIL-1:0] PERFIL_NULO = 3'b000;
  localparam int BITS_QUADRO = 6;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DADOS,
    PARIDADE,
    STOP
  } estado_t;

  function automatic logic paridade_par(input logic [LARGURA_PERFIL-1:0] p);
    return ^p;
  endfunction

endpackage

// File: rtl/transmissor_perfil_serial_divisor_baud.sv
// rtl/transmissor_perfil_serial_divisor_baud.sv - bit-period tick generator, one tick every DIV_BAUD cycles
module divisor_baud #(
  parameter int DIV_BAUD = 4
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic limpa_i,
  output logic tick_o
);

  localparam int LARG = $clog2(DIV_BAUD) + 1;
  localparam logic [LARG-1:0] ULTIMO = LARG'(DIV_BAUD - 1);

  logic [LARG-1:0] cont_q, cont_d;

  // Tick fires on the last cycle of a bit so the FSM moves exactly on the bit boundary.
  assign tick_o = (cont_q == ULTIMO);

  always_comb begin
    cont_d = cont_q + 1'b1;
    if (tick_o) cont_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i || limpa_i) cont_q <= '0;
    else                    cont_q <= cont_d;
  end

endmodule

// File: rtl/transmissor_perfil_serial.sv
// rtl/transmissor_perfil_serial.sv - framed serial transmitter: start, 3 data bits LSB first, even parity, stop
module transmissor_perfil_serial
  import perfil_pkg::*;
#(
  parameter int DIV_BAUD       = 4,
  parameter int LARGURA_PERFIL = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [LARGURA_PERFIL-1:0] perfil,
  input  logic                      valido,
  output logic                      pronto,
  output logic                      tx,
  output logic                      ocupado,
  output logic                      fim
);

  localparam int LARG_BIT = $clog2(LARGURA_PERFIL);
  localparam logic [LARG_BIT-1:0] ULTIMO_BIT = LARG_BIT'(LARGURA_PERFIL - 1);

  estado_t                   estado_q;
  logic                      tx_q;
  logic                      fim_q;
  logic [LARGURA_PERFIL-1:0] desloc_q;
  logic                      paridade_q;
  logic [LARG_BIT-1:0]       cont_bit_q;
  logic                      aceita;
  logic                      tick;

  assign aceita  = valido && (estado_q == IDLE) && (perfil != PERFIL_NULO);
  assign pronto  = (estado_q == IDLE);
  assign ocupado = !pronto;
  assign tx      = tx_q;
  assign fim     = fim_q;

  divisor_baud #(.DIV_BAUD(DIV_BAUD)) u_divisor (
    .clk_i   (clk),
    .reset_i (reset),
    .limpa_i (aceita),
    .tick_o  (tick)
  );

  // tx is loaded with the value of the state being entered, so it is already correct the cycle after each edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q   <= IDLE;
      tx_q       <= 1'b1;
      fim_q      <= 1'b0;
      desloc_q   <= '0;
      paridade_q <= 1'b0;
      cont_bit_q <= '0;
    end else begin
      fim_q <= 1'b0;
      case (estado_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (aceita) begin
            estado_q   <= START;
            tx_q       <= 1'b0;
            desloc_q   <= perfil;
            paridade_q <= paridade_par(perfil);
            cont_bit_q <= '0;
          end
        end
        START: begin
          if (tick) begin
            estado_q <= DADOS;
            tx_q     <= desloc_q[0];
          end
        end
        DADOS: begin
          if (tick) begin
            if (cont_bit_q == ULTIMO_BIT) begin
              estado_q <= PARIDADE;
              tx_q     <= paridade_q;
            end else begin
              cont_bit_q <= cont_bit_q + 1'b1;
              desloc_q   <= desloc_q >> 1;
              tx_q       <= desloc_q[1];
            end
          end
        end
        PARIDADE: begin
          if (tick) begin
            estado_q <= STOP;
            tx_q     <= 1'b1;
          end
        end
        STOP: begin
          if (tick) begin
            estado_q   <= IDLE;
            fim_q      <= 1'b1;
            cont_bit_q <= '0;
          end
        end
        default: begin
          estado_q <= IDLE;
          tx_q     <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_transmissor_perfil_serial.sv
// tb/tb_transmissor_perfil_serial.sv - directed self-checking bench for transmissor_perfil_serial
module tb_transmissor_perfil_serial;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] perfil0, perfil1;
  logic       valido0, valido1;
  logic       pronto0, tx0, ocupado0, fim0;
  logic       pronto1, tx1, ocupado1, fim1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  transmissor_perfil_serial #(.DIV_BAUD(4), .LARGURA_PERFIL(3)) u0 (
    .clk     (clk),
    .reset   (reset),
    .perfil  (perfil0),
    .valido  (valido0),
    .pronto  (pronto0),
    .tx      (tx0),
    .ocupado (ocupado0),
    .fim     (fim0)
  );

  transmissor_perfil_serial #(.DIV_BAUD(1), .LARGURA_PERFIL(3)) u1 (
    .clk     (clk),
    .reset   (reset),
    .perfil  (perfil1),
    .valido  (valido1),
    .pronto  (pronto1),
    .tx      (tx1),
    .ocupado (ocupado1),
    .fim     (fim1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [5:0] quadro;
  int         n_fim;
  int         fase;

  initial begin
    reset   = 1'b1;
    perfil0 = 3'b000;
    valido0 = 1'b0;
    perfil1 = 3'b000;
    valido1 = 1'b0;
    step();
    step();
    reset = 1'b0;

    // Idle after reset: {tx, pronto, ocupado, fim} = 1100
    for (int i = 0; i < 20; i++) begin
      step();
      chk("idle_reset", {28'd0, tx0, pronto0, ocupado0, fim0}, 32'b1100);
    end

    // Frame 101, D=4: bits start..stop = 0,1,0,1,0,1
    quadro  = 6'b101010;
    perfil0 = 3'b101;
    valido0 = 1'b1;
    step();
    valido0 = 1'b0;
    for (int j = 0; j < 24; j++) begin
      if (j > 0) step();
      chk("f101_tx", {31'd0, tx0}, {31'd0, quadro[j/4]});
      chk("f101_busy", {30'd0, ocupado0, fim0}, 32'b10);
    end
    step();
    chk("f101_end", {28'd0, tx0, pronto0, ocupado0, fim0}, 32'b1101);
    step();
    chk("f101_fim_once", {31'd0, fim0}, 32'd0);

    // Two back-to-back frames of 111 with valido held: parity 1, period 25
    quadro  = 6'b111110;
    perfil0 = 3'b111;
    valido0 = 1'b1;
    n_fim   = 0;
    step();
    for (int j = 0; j < 50; j++) begin
      if (j > 0) step();
      fase = j % 25;
      if (fim0) n_fim++;
      if (fase < 24) chk("f111_tx", {31'd0, tx0}, {31'd0, quadro[fase/4]});
      else           chk("f111_tx_idle", {31'd0, tx0}, 32'd1);
      chk("f111_fim", {31'd0, fim0}, {31'd0, fase == 24});
    end
    valido0 = 1'b0;
    chk("f111_fim_count", n_fim, 2);
    step();
    chk("f111_stop_idle", {28'd0, tx0, pronto0, ocupado0, fim0}, 32'b1100);

    // Null profile is ignored
    perfil0 = 3'b000;
    valido0 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("nulo", {28'd0, tx0, pronto0, ocupado0, fim0}, 32'b1100);
    end
    valido0 = 1'b0;

    // Frame 100 aborted by reset at cycle 9; perfil changed mid-frame
    perfil0 = 3'b100;
    valido0 = 1'b1;
    step();
    valido0 = 1'b0;
    for (int j = 0; j < 9; j++) begin
      if (j > 0) step();
      if (j == 3) perfil0 = 3'b011;
    end
    chk("abort_tx_d1", {29'd0, tx0, ocupado0, fim0}, 32'b010);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_reset", {28'd0, tx0, pronto0, ocupado0, fim0}, 32'b1100);
    n_fim = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (fim0 || !tx0) n_fim++;
    end
    chk("abort_no_fim", n_fim, 0);

    // New frame 011: bits 0,1,1,0,0,1
    quadro  = 6'b100110;
    valido0 = 1'b1;
    step();
    valido0 = 1'b0;
    for (int j = 0; j < 24; j++) begin
      if (j > 0) step();
      chk("f011_tx", {31'd0, tx0}, {31'd0, quadro[j/4]});
    end
    step();
    chk("f011_end", {28'd0, tx0, pronto0, ocupado0, fim0}, 32'b1101);

    // D=1, frame 100: 0,0,0,1,1,1 then fim, next acceptance 7 cycles later
    quadro  = 6'b111000;
    perfil1 = 3'b100;
    valido1 = 1'b1;
    step();
    for (int j = 0; j < 6; j++) begin
      if (j > 0) step();
      chk("d1_tx", {31'd0, tx1}, {31'd0, quadro[j]});
      chk("d1_busy", {30'd0, ocupado1, fim1}, 32'b10);
    end
    step();
    chk("d1_end", {28'd0, tx1, pronto1, ocupado1, fim1}, 32'b1101);
    step();
    valido1 = 1'b0;
    chk("d1_next_start", {28'd0, tx1, pronto1, ocupado1, fim1}, 32'b0010);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
